// File: rtl/scanout_engine.sv
// Raster scan-out engine: programmable VGA/DVI timing fed from a prefetch FIFO over a valid/ready pixel stream.
// Define SCANOUT_TESTPAT_EN to add the test_pat input and the colour-bar generator.
module scanout_engine #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int COLORS      = 3,
  parameter int COLOR_DEPTH = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int PREFILL     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            pix_valid,
  input  logic [COLORS*COLOR_DEPTH-1:0]   pix_data,
  output logic                            pix_ready,
  output logic                            frame_start,
  output logic [COLOR_DEPTH-1:0]          vga_r,
  output logic [COLOR_DEPTH-1:0]          vga_g,
  output logic [COLOR_DEPTH-1:0]          vga_b,
  output logic                            vga_hsync,
  output logic                            vga_vsync,
  output logic                            vga_de,
  output logic                            underflow,
  input  logic                            underflow_clr,
`ifdef SCANOUT_TESTPAT_EN
  input  logic                            test_pat,
`endif
  output logic [1:0]                      dbg_state
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int DW      = COLORS * COLOR_DEPTH;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PREFILL = 2'd1, S_RUN = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [31:0]            xi, yi;
  logic [DW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          fifo_count;
  logic [DW-1:0]          head;
  logic                   fifo_full, fifo_empty, push, pop, flush, flush_frame, fs_nxt;
  logic                   frame_end, active, uf_set, uf_frame, pat_on, hs_on, vs_on;
  logic [COLOR_DEPTH-1:0] bar_r, bar_g, bar_b, nxt_r, nxt_g, nxt_b;

`ifdef SCANOUT_TESTPAT_EN
  logic [2:0] bar_idx;
  assign pat_on  = test_pat;
  assign bar_idx = 3'((xi * 32'd8) / 32'(H_DISPLAY));
  assign bar_r   = {COLOR_DEPTH{bar_idx[2]}};
  assign bar_g   = {COLOR_DEPTH{bar_idx[1]}};
  assign bar_b   = {COLOR_DEPTH{bar_idx[0]}};
`else
  assign pat_on  = 1'b0;
  assign bar_r   = '0;
  assign bar_g   = '0;
  assign bar_b   = '0;
`endif

  assign xi         = 32'(x);
  assign yi         = 32'(y);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign head       = mem[rd_ptr];
  assign frame_end  = (xi == H_TOTAL - 1) && (yi == V_TOTAL - 1);
  assign active     = (state == S_RUN) && (xi < H_DISPLAY) && (yi < V_DISPLAY);
  assign pop        = active & ~pat_on & ~fifo_empty;
  assign uf_set     = active & ~pat_on & fifo_empty;
  assign flush      = (state == S_IDLE) | flush_frame;
  assign hs_on      = (state == S_RUN) && (xi >= H_DISPLAY + H_FRONT) && (xi < H_DISPLAY + H_FRONT + H_SYNC);
  assign vs_on      = (state == S_RUN) && (yi >= V_DISPLAY + V_FRONT) && (yi < V_DISPLAY + V_FRONT + V_SYNC);
  assign dbg_state  = state;

  // Stream handshake: a pixel transfers on any cycle with pix_valid & pix_ready; pix_ready never
  // depends on pix_valid, and upstream must hold pix_data stable while pix_valid waits for ready.
  assign pix_ready  = (state != S_IDLE) & ~fifo_full & ~flush & ~pat_on;
  assign push       = pix_valid & pix_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A mid-frame enable drop is only honoured at frame end so the monitor always sees whole frames.
  always_comb begin
    state_nxt   = state;
    fs_nxt      = 1'b0;
    flush_frame = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_PREFILL;
          fs_nxt    = 1'b1;
        end
      end
      S_PREFILL: begin
        if (!enable)                                       state_nxt = S_IDLE;
        else if ((fifo_count >= CW'(PREFILL)) || pat_on)   state_nxt = S_RUN;
      end
      S_RUN: begin
        if (frame_end) begin
          if (!enable) begin
            state_nxt = S_IDLE;
          end else if (uf_frame) begin
            flush_frame = 1'b1;
            fs_nxt      = 1'b1;
            state_nxt   = S_PREFILL;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (state != S_RUN) begin
      x <= '0;
      y <= '0;
    end else if (xi == H_TOTAL - 1) begin
      x <= '0;
      y <= (yi == V_TOTAL - 1) ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    nxt_r = '0;
    nxt_g = '0;
    nxt_b = '0;
    if (active && pat_on) begin
      nxt_r = bar_r;
      nxt_g = bar_g;
      nxt_b = bar_b;
    end else if (pop) begin
      nxt_r = head[DW-1 -: COLOR_DEPTH];
      nxt_g = head[DW-COLOR_DEPTH-1 -: COLOR_DEPTH];
      nxt_b = head[DW-2*COLOR_DEPTH-1 -: COLOR_DEPTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_de      <= 1'b0;
      vga_hsync   <= ~HSYNC_POL;
      vga_vsync   <= ~VSYNC_POL;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      uf_frame    <= 1'b0;
    end else begin
      vga_r       <= nxt_r;
      vga_g       <= nxt_g;
      vga_b       <= nxt_b;
      vga_de      <= active;
      vga_hsync   <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vga_vsync   <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      frame_start <= fs_nxt;
      underflow   <= uf_set | (underflow & ~underflow_clr);
      uf_frame    <= ((state != S_RUN) || frame_end) ? 1'b0 : (uf_frame | uf_set);
    end
  end

endmodule
